// File: rtl/status_link_tx.sv
// Status-report transmitter: buffers 24-bit words in a small FIFO and
// serialises each word MSB-first as three bytes over a valid/ready link.
module status_link_tx #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [23:0]           in_data,
   input  logic                  in_wr,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  ovf_clear
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_B2   = 2'd1,
      ST_B1   = 2'd2,
      ST_B0   = 2'd3
   } state_t;

   state_t                  state_r, state_s;
   logic [23:0]             mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0]   wptr_r, rptr_r;
   logic [DEPTH_LOG2:0]     level_r;
   logic [23:0]             hold_r;
   logic [7:0]              tx_data_r, tx_data_s;
   logic                    tx_valid_r, tx_valid_s;
   logic                    overflow_r;
   logic                    fifo_empty_s, fifo_full_s, xfer_s;
   logic                    pop_s, push_s, drop_s;
   logic [23:0]             head_s;

   assign fifo_empty_s = (level_r == '0);
   assign fifo_full_s  = (level_r == LVL_FULL);
   assign xfer_s       = tx_valid_r & tx_ready;
   assign head_s       = mem_r[rptr_r];
   // A full FIFO still accepts a word when the same cycle frees a slot.
   assign push_s       = in_wr & (~fifo_full_s | pop_s);
   assign drop_s       = in_wr & fifo_full_s & ~pop_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; pop decisions use the pre-write FIFO level
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: if (!fifo_empty_s) state_s = ST_B2; else state_s = ST_IDLE;
         ST_B2:   if (xfer_s) state_s = ST_B1; else state_s = ST_B2;
         ST_B1:   if (xfer_s) state_s = ST_B0; else state_s = ST_B1;
         ST_B0: begin
            if (xfer_s) begin
               if (!fifo_empty_s) state_s = ST_B2;
               else               state_s = ST_IDLE;
            end else begin
               state_s = ST_B0;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Output logic: pop strobe and next value of the registered byte outputs
   always_comb begin
      pop_s      = (state_s == ST_B2) && (state_r != ST_B2);
      tx_valid_s = 1'b0;
      tx_data_s  = tx_data_r;
      case (state_s)
         ST_B2: begin
            tx_valid_s = 1'b1;
            if (pop_s) tx_data_s = head_s[23:16];
            else       tx_data_s = tx_data_r;
         end
         ST_B1: begin
            tx_valid_s = 1'b1;
            tx_data_s  = hold_r[15:8];
         end
         ST_B0: begin
            tx_valid_s = 1'b1;
            tx_data_s  = hold_r[7:0];
         end
         default: begin
            tx_valid_s = 1'b0;
            tx_data_s  = tx_data_r;
         end
      endcase
   end

   // Registered link outputs and holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_r <= 1'b0;
         tx_data_r  <= 8'h00;
         hold_r     <= 24'h000000;
      end else begin
         tx_valid_r <= tx_valid_s;
         tx_data_r  <= tx_data_s;
         if (pop_s) hold_r <= head_s;
      end
   end

   // FIFO storage; stale contents are unreachable once pointers reset
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wptr_r] <= in_data;
   end

   // FIFO pointers, occupancy counter and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r     <= '0;
         rptr_r     <= '0;
         level_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wptr_r <= wptr_r + PTR_ONE;
         if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
         if (drop_s)         overflow_r <= 1'b1;
         else if (ovf_clear) overflow_r <= 1'b0;
      end
   end

   assign tx_data  = tx_data_r;
   assign tx_valid = tx_valid_r;
   assign level    = level_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_status_link_tx.sv
// Self-checking bench for status_link_tx: byte scoreboard fed at write time,
// table-driven word vectors, and hand-written multi-cycle corner sequences.
module tb_status_link_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] in_data;
   logic        in_wr;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  level;
   logic        overflow;
   logic        ovf_clear;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [23:0] word;
      logic [7:0]  b2;
      logic [7:0]  b1;
      logic [7:0]  b0;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   status_link_tx #(.DEPTH_LOG2(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_wr     (in_wr),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .level     (level),
      .overflow  (overflow),
      .ovf_clear (ovf_clear)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [23:0] w);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   // Drive one write; sampled at the next rising edge, returns #1 after it.
   task automatic write_word(input logic [23:0] w, input bit expect_out);
      in_data = w;
      in_wr   = 1'b1;
      if (expect_out) push_word(w);
      @(posedge clk); #1;
      in_wr = 1'b0;
   endtask

   // Every link transfer is compared with the next expected byte.
   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_unexpected: got %0h expected none", tx_data);
         end else begin
            check("byte", {24'h000000, tx_data}, {24'h000000, exp_q.pop_front()});
         end
      end
   end

   initial begin
      vecs[0] = '{24'h000000, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[2] = '{24'h123456, 8'h12, 8'h34, 8'h56};
      vecs[3] = '{24'h80017F, 8'h80, 8'h01, 8'h7F};
      vecs[4] = '{24'h5A5AA5, 8'h5A, 8'h5A, 8'hA5};
      vecs[5] = '{24'hC0FFEE, 8'hC0, 8'hFF, 8'hEE};

      rst_n = 1'b0; in_data = 24'h000000; in_wr = 1'b0;
      tx_ready = 1'b0; ovf_clear = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_data", {24'd0, tx_data}, 32'd0);
      check("rst_level", {28'd0, level}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_ready = 1'b1;

      // Single word: latency and byte order
      write_word(24'hA5C3F0, 1'b1);
      @(negedge clk);
      check("sw_level1", {28'd0, level}, 32'd1);
      check("sw_valid_n1", {31'd0, tx_valid}, 32'd0);
      @(negedge clk);
      check("sw_b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
      @(negedge clk);
      check("sw_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hC3});
      @(negedge clk);
      check("sw_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hF0});
      @(negedge clk);
      check("sw_idle_valid", {31'd0, tx_valid}, 32'd0);
      check("sw_idle_level", {28'd0, level}, 32'd0);

      // Backpressure during B1
      @(posedge clk); #1;
      write_word(24'hA5C3F0, 1'b1);
      @(posedge clk);
      @(posedge clk); #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hC3});
         @(posedge clk);
      end
      #1 tx_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("bp_done_valid", {31'd0, tx_valid}, 32'd0);

      // Table vectors at the sustainable rate of one word per three cycles
      for (int i = 0; i < 6; i++) begin
         in_data = vecs[i].word;
         in_wr   = 1'b1;
         exp_q.push_back(vecs[i].b2);
         exp_q.push_back(vecs[i].b1);
         exp_q.push_back(vecs[i].b0);
         @(posedge clk); #1;
         in_wr = 1'b0;
         repeat (2) begin @(posedge clk); #1; end
         check("tbl_no_ovf", {31'd0, overflow}, 32'd0);
      end
      repeat (6) @(posedge clk);
      #1;
      check("tbl_drain_valid", {31'd0, tx_valid}, 32'd0);
      check("tbl_drain_queue", exp_q.size(), 32'd0);

      // Overflow: one word held, eight buffered, the tenth dropped
      tx_ready = 1'b0;
      for (int i = 1; i <= 10; i++) write_word(24'(i), i <= 9);
      @(negedge clk);
      check("ovf_level", {28'd0, level}, 32'd8);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_head", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h00});

      // Clear and set in the same cycle: set wins
      @(posedge clk); #1;
      in_data = 24'h00000B; in_wr = 1'b1; ovf_clear = 1'b1;
      @(posedge clk); #1;
      in_wr = 1'b0; ovf_clear = 1'b0;
      @(negedge clk);
      check("clr_vs_set", {31'd0, overflow}, 32'd1);
      check("clr_vs_set_level", {28'd0, level}, 32'd8);
      @(posedge clk); #1;
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      @(negedge clk);
      check("clr_alone", {31'd0, overflow}, 32'd0);

      // Full FIFO with a write in the cycle of the B0 transfer
      @(posedge clk); #1;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      write_word(24'hABCDEF, 1'b1);
      @(negedge clk);
      check("fullpop_level", {28'd0, level}, 32'd8);
      check("fullpop_ovf", {31'd0, overflow}, 32'd0);
      check("fullpop_next", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h00});
      repeat (40) @(posedge clk);
      #1;
      check("full_drain_valid", {31'd0, tx_valid}, 32'd0);
      check("full_drain_level", {28'd0, level}, 32'd0);
      check("full_drain_queue", exp_q.size(), 32'd0);

      // Reset in B1 with three words buffered
      tx_ready = 1'b0;
      exp_q.push_back(8'h11);
      write_word(24'h11AA55, 1'b0);
      write_word(24'h222222, 1'b0);
      write_word(24'h333333, 1'b0);
      write_word(24'h444444, 1'b0);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      @(negedge clk);
      check("mid_level", {28'd0, level}, 32'd3);
      check("mid_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
      check("mid_queue", exp_q.size(), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, tx_valid}, 32'd0);
      check("arst_level", {28'd0, level}, 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_ready = 1'b1;
      write_word(24'h123456, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("post_rst_queue", exp_q.size(), 32'd0);
      check("post_rst_ovf", {31'd0, overflow}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/status_link_tx.md
# status_link_tx

Transmit-side consumer of the 24-bit status-report channel: it accepts words from producers such as the key/lock status block (`out_data` with a single-cycle `out_wr` request) and buffers them in a small FIFO. It then serialises each word into three bytes, MSB first, over a valid/ready byte interface feeding the host link transmitter. The producer side has no backpressure, so this block absorbs bursts and flags any loss.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 words (default 8). Legal range 1..6.
- `clk`: input, 1 bit. Single system clock; all logic is on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_data`: input, 24 bits. Report word from the producer.
- `in_wr`: input, 1 bit. One-cycle write request. Every high cycle is one distinct word.
- `tx_data`: output, 8 bits. Byte to the link transmitter.
- `tx_valid`: output, 1 bit. `tx_data` holds a valid byte.
- `tx_ready`: input, 1 bit. Link accepts the byte. A transfer happens when `tx_valid & tx_ready`.
- `level`: output, DEPTH_LOG2+1 bits. Number of words in the FIFO. Excludes the word currently being serialised.
- `overflow`: output, 1 bit. Sticky flag: at least one word was dropped.
- `ovf_clear`: input, 1 bit. Synchronous clear of `overflow`.

## Operation
- Reset values: `tx_valid`=0, `tx_data`=0, `level`=0, `overflow`=0. The FIFO pointers are zeroed and the FSM is in IDLE.
- **FIFO write**
  - Condition: `in_wr` is high and either `level` < 2^DEPTH_LOG2 or a pop occurs in the same cycle.
  - A full FIFO plus a same-cycle pop therefore accepts the word; `level` stays at full.
- **Drop**
  - Condition: `in_wr` is high, the FIFO is full, and no pop occurs that cycle.
  - The word is discarded, `overflow` is set, and FIFO contents are unchanged.
- **`overflow` update**
  - A set and `ovf_clear` in the same cycle leave the flag at 1 (set wins).
  - Otherwise `ovf_clear` writes 0.
- **FSM states**: IDLE, B2, B1, B0. Byte mapping: B2 sends word[23:16], B1 sends [15:8], B0 sends [7:0].
- **IDLE**
  - If the FIFO is non-empty: pop the head into a 24-bit holding register and go to B2.
  - `tx_valid` is 0 in IDLE.
- **B2 / B1**
  - `tx_valid`=1.
  - On transfer, advance to the next state.
  - Without a transfer, hold the state; `tx_data` stays stable.
- **B0**
  - `tx_valid`=1.
  - On transfer with the FIFO non-empty: pop the next word and go directly to B2, with no idle bubble.
  - On transfer with the FIFO empty: go to IDLE.
- **Pop timing**: a pop happens only in IDLE→B2 or in B0-with-transfer→B2. Pop decisions use the FIFO state before the same cycle's write, so a word written in cycle N cannot be popped before cycle N+1.
- **Outputs**: `tx_data` and `tx_valid` are registered outputs. No combinational path from `tx_ready` to `tx_valid`/`tx_data`.
- **Pointers**: wrap modulo 2^DEPTH_LOG2. `level` is a separate counter (or pointer difference with an extra bit) and is exact when full.

## Timing
- **Latency, empty block**: `in_wr` in cycle N → `level`=1 in N+1 → pop in N+1 → `tx_valid`=1 with the B2 byte in N+2.
- **Throughput**: with `tx_ready` held high, 1 byte/cycle, i.e. 3 cycles per word, back-to-back across words.
- **Sustainable input rate**: the producer may write at most one word per 3 cycles long-term. Bursts up to 2^DEPTH_LOG2 words plus the in-flight word are lossless.
- **`level`**: updates the cycle after write/pop. Simultaneous write and pop leave it unchanged.
- **Reset during a word**: asserting `rst_n` low in any state forces IDLE. `tx_valid` drops to 0 immediately (asynchronously) and FIFO contents are discarded. The partial word is not resumed after release.
- **After `rst_n` deassertion**: the first `in_wr` is honoured on the first rising edge with `rst_n` high.

## Test plan
- **Single word**:
  - Stimulus: reset, then in_wr with 0xA5C3F0 at cycle 10, `tx_ready`=1.
  - Response: `tx_valid` high in cycles 12–14 with bytes 0xA5, 0xC3, 0xF0; then `tx_valid`=0 and `level`=0.
- **Backpressure**:
  - Stimulus: same word, `tx_ready` low for 5 cycles during B1.
  - Response: `tx_data` stays 0xC3 with `tx_valid`=1 throughout; sequence completes with no byte duplicated or skipped.
- **Overflow**:
  - Stimulus: `tx_ready`=0, write 10 consecutive words 0x000001..0x00000A.
  - Response: word 1 in holding register, words 2–9 in FIFO (`level`=8), word 10 dropped, `overflow`=1.
  - After releasing `tx_ready`, the bytes of words 1–9 appear in order.
- **Full + simultaneous pop**:
  - Stimulus: with FIFO full, assert in_wr in the same cycle as the B0 transfer.
  - Response: word accepted, `level` stays 8, `overflow` stays 0.
- **Clear vs set**:
  - Stimulus: `ovf_clear` asserted in the same cycle as a drop.
  - Response: `overflow`=1.
  - Stimulus: `ovf_clear` alone on a later cycle.
  - Response: `overflow`=0 the next cycle.
- **Reset mid-word**:
  - Stimulus: assert `rst_n` low while in B1 with `level`=3.
  - Response: `tx_valid`=0 and `level`=0 immediately.
  - After release, a new word 0x123456 emits 0x12, 0x34, 0x56 only.
